cic_decim_ctrl: RTL and testbench

- Sequencing controller for the CIC decimator datapath.
- Owns the decimation phase counter and issues the single-cycle comb-section advance strobe at a programmable ratio.
- Discards the comb pipeline's warm-up samples, then captures decimated samples into a one-entry valid/ready output register with sticky overrun detection.
- Sits between the free-running integrator/comb datapath and the downstream sample consumer.

---
 rtl/cic_decim_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cic_decim_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// cic_decim_ctrl
//
// Sequencing controller for a CIC decimator datapath. Runs the decimation
// phase counter, issues a single-cycle comb-section advance strobe once every
// R clocks, discards the comb pipeline's warm-up outputs, and captures the
// decimated samples into a one-entry valid/ready output register with a
// sticky overrun flag.
//
// Ports:
//   clk              sole clock
//   rst              asynchronous, active-high reset
//   i_cfg_we         load i_cfg_ratio_m1 (only honoured in IDLE)
//   i_cfg_ratio_m1   decimation ratio minus one (R-1); 0 is coerced to 1
//   i_enable         run request; dropping it returns the FSM to IDLE
//   o_comb_en        one-cycle comb advance strobe
//   i_comb_data      combinational comb output, valid in the o_comb_en cycle
//   o_out_data       captured sample (MSBs of i_comb_data)
//   o_out_valid      o_out_data holds an unconsumed sample
//   i_out_ready      consumer accepts when o_out_valid && i_out_ready
//   o_overrun        sticky: an unconsumed sample was overwritten
//   o_state          00 IDLE, 01 WARMUP, 10 RUN
// -----------------------------------------------------------------------------
module cic_decim_ctrl #(
  parameter int STAGES     = 4,
  parameter int WIDTH_CTR  = 4,
  parameter int WIDTH_DATA = 17,
  parameter int OUT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cfg_we,
  input  logic [WIDTH_CTR-1:0]  i_cfg_ratio_m1,
  input  logic                  i_enable,
  output logic                  o_comb_en,
  input  logic [WIDTH_DATA-1:0] i_comb_data,
  output logic [OUT_WIDTH-1:0]  o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_overrun,
  output logic [1:0]            o_state
);

  localparam int WARM_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(STAGES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WARMUP = 2'b01,
    ST_RUN    = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH_CTR-1:0]  r_phase;
  logic [WIDTH_CTR-1:0]  w_phase_next;
  logic [WIDTH_CTR-1:0]  r_ratio;
  logic [WIDTH_CTR-1:0]  w_ratio_next;
  logic [WARM_W-1:0]     r_warm;
  logic                  r_comb_en;
  logic                  w_comb_en_next;
  logic                  w_strobe;
  logic                  w_capture;
  logic                  w_cfg_load;
  logic [OUT_WIDTH-1:0]  r_out_data;
  logic                  r_out_valid;
  logic                  r_overrun;

  // The strobe is decoded one cycle early into r_comb_en; gating it with
  // i_enable kills it in the very cycle the run request drops.
  assign w_strobe   = r_comb_en && i_enable && (r_state != ST_IDLE);
  assign w_capture  = w_strobe && (r_state == ST_RUN);
  assign w_cfg_load = i_cfg_we && (r_state == ST_IDLE);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and counter next-values
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = '0;
    w_ratio_next = r_ratio;

    case (r_state)
      ST_IDLE: begin
        if (i_enable) w_state_next = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (!i_enable) begin
          w_state_next = ST_IDLE;
        end else if (w_strobe && (r_warm == WARM_LAST)) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_enable) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Phase runs 0..ratio only while active; entering or leaving IDLE clears it.
    if ((r_state != ST_IDLE) && i_enable) begin
      w_phase_next = (r_phase == r_ratio) ? '0 : r_phase + WIDTH_CTR'(1);
    end

    // A ratio of zero would give R=1 (strobe every cycle); coerce to R=2.
    if (w_cfg_load) begin
      w_ratio_next = (i_cfg_ratio_m1 == '0) ? WIDTH_CTR'(1) : i_cfg_ratio_m1;
    end

    w_comb_en_next = (w_state_next != ST_IDLE) && (w_phase_next == w_ratio_next);
  end

  // ---------------------------------------------------------------------------
  // Phase, ratio, warm-up count and strobe registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= '0;
      r_ratio   <= '1;
      r_warm    <= '0;
      r_comb_en <= 1'b0;
    end else begin
      r_phase   <= w_phase_next;
      r_ratio   <= w_ratio_next;
      r_comb_en <= w_comb_en_next;
      if (r_state == ST_IDLE) begin
        r_warm <= '0;
      end else if ((r_state == ST_WARMUP) && w_strobe && (r_warm != WARM_LAST)) begin
        r_warm <= r_warm + WARM_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output sample register and handshake
  // ---------------------------------------------------------------------------
  // A capture always wins over an accept: the new sample loads and valid
  // stays high. Overrun is flagged only when the held sample was not taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_data  <= i_comb_data[WIDTH_DATA-1 -: OUT_WIDTH];
        r_out_valid <= 1'b1;
        if (r_out_valid && !i_out_ready) r_overrun <= 1'b1;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Captures only happen in RUN, so this never races the set above.
      if (w_cfg_load) r_overrun <= 1'b0;
    end
  end

  // The comb LSBs below the output field are dropped by design.
  logic w_unused_lsbs;
  assign w_unused_lsbs = ^i_comb_data[WIDTH_DATA-OUT_WIDTH-1:0];

  assign o_comb_en   = w_strobe;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;
  assign o_state     = r_state;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_ctrl
//
// Directed self-checking bench for cic_decim_ctrl. Each task drives one
// scenario and compares outputs against hand-computed expectations. Inputs
// change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_cic_decim_ctrl;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_WARMUP = 2'b01;
  localparam logic [1:0] S_RUN    = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cfg_we;
  logic [3:0]  i_cfg_ratio_m1;
  logic        i_enable;
  logic        o_comb_en;
  logic [16:0] i_comb_data;
  logic [6:0]  o_out_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic        o_overrun;
  logic [1:0]  o_state;

  int n_checks = 0;
  int n_errors = 0;

  cic_decim_ctrl #(
    .STAGES(4), .WIDTH_CTR(4), .WIDTH_DATA(17), .OUT_WIDTH(7)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_ratio_m1 (i_cfg_ratio_m1),
    .i_enable       (i_enable),
    .o_comb_en      (o_comb_en),
    .i_comb_data    (i_comb_data),
    .o_out_data     (o_out_data),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_overrun      (o_overrun),
    .o_state        (o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] m1);
    i_cfg_we       = 1'b1;
    i_cfg_ratio_m1 = m1;
    step();
    i_cfg_we       = 1'b0;
  endtask

  task automatic go_idle_drain();
    i_enable    = 1'b0;
    i_out_ready = 1'b1;
    step();
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; i_cfg_we = 1'b0; i_cfg_ratio_m1 = '0; i_enable = 1'b0;
    i_comb_data = '0; i_out_ready = 1'b0;
    step();
    n_checks++; if (o_state !== S_IDLE) begin n_errors++; $display("FAIL rst_state got %b exp %b", o_state, S_IDLE); end
    n_checks++; if (o_comb_en !== 1'b0) begin n_errors++; $display("FAIL rst_comb_en got %b exp 0", o_comb_en); end
    n_checks++; if (o_out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid got %b exp 0", o_out_valid); end
    n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL rst_overrun got %b exp 0", o_overrun); end
    n_checks++; if (o_out_data !== 7'd0) begin n_errors++; $display("FAIL rst_out_data got %h exp 00", o_out_data); end
    step();
    #3 rst = 1'b0;
    step();
  endtask

  // R=12: strobes every 12 cycles, 4 discarded, 5th captured.
  task automatic test_warmup_run();
    logic       exp_en;
    logic [1:0] exp_st;
    logic       exp_v;
    cfg(4'd11);
    i_out_ready = 1'b1;
    i_enable    = 1'b1;
    for (int k = 1; k <= 62; k++) begin
      step();
      i_comb_data = (k == 60) ? 17'h15A5A : 17'h1FFFF;
      #1;
      exp_en = (k % 12 == 0);
      exp_st = (k <= 48) ? S_WARMUP : S_RUN;
      exp_v  = (k == 61);
      n_checks++; if (o_comb_en !== exp_en) begin n_errors++; $display("FAIL wr_comb_en k=%0d got %b exp %b", k, o_comb_en, exp_en); end
      n_checks++; if (o_state !== exp_st) begin n_errors++; $display("FAIL wr_state k=%0d got %b exp %b", k, o_state, exp_st); end
      n_checks++; if (o_out_valid !== exp_v) begin n_errors++; $display("FAIL wr_out_valid k=%0d got %b exp %b", k, o_out_valid, exp_v); end
      if (k == 61) begin
        // 17'h15A5A[16:10] = 7'h56
        n_checks++; if (o_out_data !== 7'h56) begin n_errors++; $display("FAIL wr_out_data got %h exp 56", o_out_data); end
      end
    end
    i_enable = 1'b0;
    step();
    n_checks++; if (o_state !== S_IDLE) begin n_errors++; $display("FAIL wr_idle got %b exp %b", o_state, S_IDLE); end
  endtask

  // ratio_m1=0 coerces to R=2; a cfg write while running is ignored.
  task automatic test_ratio_cfg();
    logic exp_en;
    cfg(4'd0);
    i_enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      i_cfg_we       = (k == 10);
      i_cfg_ratio_m1 = 4'd5;
      i_comb_data    = '0;
      #1;
      exp_en = (k % 2 == 0);
      n_checks++; if (o_comb_en !== exp_en) begin n_errors++; $display("FAIL rc_comb_en k=%0d got %b exp %b", k, o_comb_en, exp_en); end
      if (k == 9) begin
        n_checks++; if (o_state !== S_RUN) begin n_errors++; $display("FAIL rc_state got %b exp %b", o_state, S_RUN); end
      end
    end
    i_cfg_we = 1'b0;
    go_idle_drain();
  endtask

  // Two captures without a consumer: overrun sets; cfg in IDLE clears it.
  task automatic test_overrun();
    i_out_ready = 1'b0;
    i_enable    = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      i_comb_data = (k == 10) ? 17'h00400 : (k == 12) ? 17'h1FC00 : 17'h00000;
      #1;
      if (k == 11) begin
        n_checks++; if (o_out_valid !== 1'b1) begin n_errors++; $display("FAIL ov_valid1 got %b exp 1", o_out_valid); end
        n_checks++; if (o_out_data !== 7'h01) begin n_errors++; $display("FAIL ov_data1 got %h exp 01", o_out_data); end
        n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL ov_flag1 got %b exp 0", o_overrun); end
      end
      if (k == 13) begin
        n_checks++; if (o_out_valid !== 1'b1) begin n_errors++; $display("FAIL ov_valid2 got %b exp 1", o_out_valid); end
        n_checks++; if (o_out_data !== 7'h7F) begin n_errors++; $display("FAIL ov_data2 got %h exp 7f", o_out_data); end
        n_checks++; if (o_overrun !== 1'b1) begin n_errors++; $display("FAIL ov_flag2 got %b exp 1", o_overrun); end
      end
    end
    i_enable = 1'b0;
    step();
    n_checks++; if (o_state !== S_IDLE) begin n_errors++; $display("FAIL ov_idle got %b exp %b", o_state, S_IDLE); end
    n_checks++; if (o_overrun !== 1'b1) begin n_errors++; $display("FAIL ov_sticky got %b exp 1", o_overrun); end
    cfg(4'd1);
    n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL ov_cleared got %b exp 0", o_overrun); end
    n_checks++; if (o_out_valid !== 1'b1) begin n_errors++; $display("FAIL ov_retain got %b exp 1", o_out_valid); end
    n_checks++; if (o_out_data !== 7'h7F) begin n_errors++; $display("FAIL ov_retain_data got %h exp 7f", o_out_data); end
    i_out_ready = 1'b1;
    step();
    n_checks++; if (o_out_valid !== 1'b0) begin n_errors++; $display("FAIL ov_consume got %b exp 0", o_out_valid); end
  endtask

  // Consumer accepts exactly in the cycle a new sample is captured.
  task automatic test_capture_accept();
    i_out_ready = 1'b0;
    i_enable    = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      i_comb_data = (k == 10) ? 17'h00800 : (k == 12) ? 17'h00C00 : 17'h00000;
      i_out_ready = (k == 12);
      #1;
      if (k == 11) begin
        n_checks++; if (o_out_data !== 7'h02) begin n_errors++; $display("FAIL ca_data1 got %h exp 02", o_out_data); end
      end
      if (k == 12) begin
        n_checks++; if (o_comb_en !== 1'b1) begin n_errors++; $display("FAIL ca_strobe got %b exp 1", o_comb_en); end
      end
      if (k == 13) begin
        n_checks++; if (o_out_valid !== 1'b1) begin n_errors++; $display("FAIL ca_valid got %b exp 1", o_out_valid); end
        n_checks++; if (o_out_data !== 7'h03) begin n_errors++; $display("FAIL ca_data2 got %h exp 03", o_out_data); end
        n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL ca_overrun got %b exp 0", o_overrun); end
      end
    end
    go_idle_drain();
    n_checks++; if (o_out_valid !== 1'b0) begin n_errors++; $display("FAIL ca_drain got %b exp 0", o_out_valid); end
  endtask

  // Enable drops mid-warm-up (in a strobe cycle), then re-asserts: the full
  // 4-strobe discard repeats. Ends in RUN with a held sample in a strobe cycle.
  task automatic test_warm_restart();
    logic       exp_en;
    logic       exp_v;
    logic [1:0] exp_st;
    i_enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      i_comb_data = 17'h1FFFF;
      i_enable    = (k != 6);
      #1;
      exp_en = (k == 2) || (k == 4);
      n_checks++; if (o_comb_en !== exp_en) begin n_errors++; $display("FAIL wm_comb_en k=%0d got %b exp %b", k, o_comb_en, exp_en); end
      n_checks++; if (o_out_valid !== 1'b0) begin n_errors++; $display("FAIL wm_valid k=%0d got %b exp 0", k, o_out_valid); end
    end
    step();
    n_checks++; if (o_state !== S_IDLE) begin n_errors++; $display("FAIL wm_idle got %b exp %b", o_state, S_IDLE); end
    i_enable = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step();
      i_comb_data = (j == 10) ? 17'h10000 : 17'h1FFFF;
      i_out_ready = (j < 12);
      #1;
      exp_en = (j % 2 == 0);
      exp_v  = (j == 11) || (j >= 13);
      exp_st = (j <= 8) ? S_WARMUP : S_RUN;
      n_checks++; if (o_comb_en !== exp_en) begin n_errors++; $display("FAIL wm2_comb_en j=%0d got %b exp %b", j, o_comb_en, exp_en); end
      n_checks++; if (o_out_valid !== exp_v) begin n_errors++; $display("FAIL wm2_valid j=%0d got %b exp %b", j, o_out_valid, exp_v); end
      n_checks++; if (o_state !== exp_st) begin n_errors++; $display("FAIL wm2_state j=%0d got %b exp %b", j, o_state, exp_st); end
      if (j == 11) begin
        n_checks++; if (o_out_data !== 7'h40) begin n_errors++; $display("FAIL wm2_data got %h exp 40", o_out_data); end
      end
    end
  endtask

  // Async reset between edges in RUN; ratio reverts to R=16.
  task automatic test_async_rst();
    logic exp_en;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (o_state !== S_IDLE) begin n_errors++; $display("FAIL ar_state got %b exp %b", o_state, S_IDLE); end
    n_checks++; if (o_comb_en !== 1'b0) begin n_errors++; $display("FAIL ar_comb_en got %b exp 0", o_comb_en); end
    n_checks++; if (o_out_valid !== 1'b0) begin n_errors++; $display("FAIL ar_valid got %b exp 0", o_out_valid); end
    n_checks++; if (o_out_data !== 7'd0) begin n_errors++; $display("FAIL ar_data got %h exp 00", o_out_data); end
    i_enable    = 1'b0;
    i_out_ready = 1'b1;
    #2 rst = 1'b0;
    step();
    i_enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      #1;
      exp_en = (k == 16);
      n_checks++; if (o_comb_en !== exp_en) begin n_errors++; $display("FAIL ar_r16 k=%0d got %b exp %b", k, o_comb_en, exp_en); end
    end
    i_enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_warmup_run();
    test_ratio_cfg();
    test_overrun();
    test_capture_accept();
    test_warm_restart();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
